// File: rtl/timer_irq_ctrl.sv
// timer_irq_ctrl: latches counter-done events as pending flags, counts missed events, drives a level IRQ.
// Ports: clk/rst_n (async active-low); AXI4-Lite slave i_axi_*/o_axi_* (full-word, no strobes);
//        i_cnt0_done/i_cnt1_done event inputs (pulse or level); o_irq level interrupt.
// Map: 0x00 STATUS (W1C), 0x04 ENABLE, 0x08 MISSED (write clears), 0x0C IRQ_STAT (RO), else SLVERR.
module timer_irq_ctrl #(
  parameter int AXI_ADDR_BW_p = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [AXI_ADDR_BW_p-1:0] i_axi_awaddr,
  input  logic                     i_axi_awvalid,
  input  logic [31:0]              i_axi_wdata,
  input  logic                     i_axi_wvalid,
  input  logic                     i_axi_bready,
  input  logic [AXI_ADDR_BW_p-1:0] i_axi_araddr,
  input  logic                     i_axi_arvalid,
  input  logic                     i_axi_rready,
  output logic                     o_axi_awready,
  output logic                     o_axi_wready,
  output logic [1:0]               o_axi_bresp,
  output logic                     o_axi_bvalid,
  output logic                     o_axi_arready,
  output logic [31:0]              o_axi_rdata,
  output logic [1:0]               o_axi_rresp,
  output logic                     o_axi_rvalid,
  input  logic                     i_cnt0_done,
  input  logic                     i_cnt1_done,
  output logic                     o_irq
);
  localparam int IW = AXI_ADDR_BW_p - 2;
  typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} r_state_t;
  w_state_t w_state;
  r_state_t r_state;
  logic [IW-1:0] waddr_q, raddr_q;
  logic [1:0] wdata_q, done_q, pending, enable, ev, w1c;
  logic [7:0] missed0, missed1;
  logic wr_en, w_enable, w_missed, w_bad, r_bad;
  logic [31:0] rd_mux;
  logic unused_ok;
  assign unused_ok = ^{i_axi_awaddr[1:0], i_axi_araddr[1:0], i_axi_wdata[31:2]};
  always_comb begin
    wr_en = w_state == W_ACK;
    w_enable = wr_en && waddr_q == IW'(1);
    w_missed = wr_en && waddr_q == IW'(2);
    w_bad = waddr_q > IW'(3);
    r_bad = raddr_q > IW'(3);
    w1c = (wr_en && waddr_q == IW'(0)) ? wdata_q : 2'b00;
    ev = {i_cnt1_done, i_cnt0_done} & ~done_q;
    rd_mux = raddr_q == IW'(0) ? {30'b0, pending} :
             raddr_q == IW'(1) ? {30'b0, enable} :
             raddr_q == IW'(2) ? {16'b0, missed1, missed0} :
             raddr_q == IW'(3) ? {29'b0, o_irq, pending & enable} : 32'b0;
  end
  // A same-cycle W1C on a flag that is being set again counts as serviced, so no miss is recorded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= '0;
      pending <= '0;
      enable <= '0;
      missed0 <= '0;
      missed1 <= '0;
      o_irq <= 1'b0;
    end else begin
      done_q <= {i_cnt1_done, i_cnt0_done};
      pending <= (pending & ~w1c) | ev;
      enable <= w_enable ? wdata_q : enable;
      missed0 <= w_missed ? 8'd0 :
                 (ev[0] && pending[0] && !w1c[0] && missed0 != 8'hff) ? missed0 + 8'd1 : missed0;
      missed1 <= w_missed ? 8'd0 :
                 (ev[1] && pending[1] && !w1c[1] && missed1 != 8'hff) ? missed1 + 8'd1 : missed1;
      o_irq <= |(pending & enable);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      waddr_q <= '0;
      wdata_q <= '0;
      o_axi_awready <= 1'b0;
      o_axi_wready <= 1'b0;
      o_axi_bvalid <= 1'b0;
      o_axi_bresp <= 2'b00;
    end else begin
      case (w_state)
        W_IDLE: if (i_axi_awvalid && i_axi_wvalid) begin
          w_state <= W_ACK;
          waddr_q <= i_axi_awaddr[AXI_ADDR_BW_p-1:2];
          wdata_q <= i_axi_wdata[1:0];
          o_axi_awready <= 1'b1;
          o_axi_wready <= 1'b1;
        end
        W_ACK: begin
          w_state <= W_RESP;
          o_axi_awready <= 1'b0;
          o_axi_wready <= 1'b0;
          o_axi_bvalid <= 1'b1;
          o_axi_bresp <= w_bad ? 2'b10 : 2'b00;
        end
        default: if (i_axi_bready) begin
          w_state <= W_IDLE;
          o_axi_bvalid <= 1'b0;
          o_axi_bresp <= 2'b00;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      raddr_q <= '0;
      o_axi_arready <= 1'b0;
      o_axi_rvalid <= 1'b0;
      o_axi_rdata <= '0;
      o_axi_rresp <= 2'b00;
    end else begin
      case (r_state)
        R_IDLE: if (i_axi_arvalid) begin
          r_state <= R_ACK;
          raddr_q <= i_axi_araddr[AXI_ADDR_BW_p-1:2];
          o_axi_arready <= 1'b1;
        end
        R_ACK: begin
          r_state <= R_DATA;
          o_axi_arready <= 1'b0;
          o_axi_rvalid <= 1'b1;
          o_axi_rdata <= rd_mux;
          o_axi_rresp <= r_bad ? 2'b10 : 2'b00;
        end
        default: if (i_axi_rready) begin
          r_state <= R_IDLE;
          o_axi_rvalid <= 1'b0;
        end
      endcase
    end
  end
endmodule
